param_fifo: RTL and testbench
=============================

Name: param_fifo

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's fixed 32-bit × 8 fifo, keeping the same handshake flags (ack/err per side, full/empty, data_count). It adds:
- configurable data width and depth;
- programmable almost-full and almost-empty thresholds;
- a synchronous clear;
- defined simultaneous read/write behaviour at the full and empty boundaries.

It is used as the standard buffering element between producer and consumer blocks in a single clock domain.

Parameters:
DATA_WIDTH, 32, width of d_in/d_out
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8)
AF_LEVEL, 6, almost_full asserts when data_count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when data_count <= AE_LEVEL

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; pointers and count go to 0
rd_en  input  1  read request
wr_en  input  1  write request
d_in  input  DATA_WIDTH  write data
d_out  output  DATA_WIDTH  registered read data
full  output  1  data_count == DEPTH
empty  output  1  data_count == 0
almost_full  output  1  data_count >= AF_LEVEL
almost_empty  output  1  data_count <= AE_LEVEL
wr_ack  output  1  write accepted last cycle
wr_err  output  1  write rejected last cycle (full)
rd_ack  output  1  read accepted last cycle, d_out valid
rd_err  output  1  read rejected last cycle (empty)
data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: rd_ptr=0, wr_ptr=0, count=0, d_out=0, all ack/err=0, empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- State is the count plus two ADDR_WIDTH-bit pointers. Pointers wrap naturally from DEPTH-1 to 0.
- Status flags (full, empty, almost_*) are decoded combinationally from the registered count, so they reflect the state after the last edge.
- Write acceptance: a write is accepted at the edge when wr_en=1 and (count<DEPTH, or rd_en=1 with count==DEPTH). An accepted write stores d_in at wr_ptr and increments wr_ptr.
- Read acceptance: a read is accepted at the edge when rd_en=1 and count>0. An accepted read loads mem[rd_ptr] into d_out and increments rd_ptr. Latency is 1 cycle from the rd_en edge.
- d_out holds its last value when no read is accepted, including on rd_err.
- Ack/err timing: wr_ack/wr_err and rd_ack/rd_err are registered and asserted for exactly the one cycle following the request edge. When the corresponding enable is low, both are 0.
- Rejected write (full, no concurrent read): wr_err=1; memory and wr_ptr are unchanged.
- Rejected read (empty): rd_err=1; rd_ptr is unchanged.
- Simultaneous rd_en & wr_en:
  - count==0: the write is accepted and the read errors; count becomes 1.
  - count==DEPTH: both are accepted and count is unchanged.
  - otherwise: both are accepted and count is unchanged.
  - In every case the read returns the older entry, never the word written in the same cycle.
- Count update: count += (wr_acc) - (rd_acc).
- clr has priority over rd_en/wr_en. It zeroes the pointers and count and sets all ack/err to 0. d_out is held.
- reset_n asserted mid-operation forces the reset values immediately, independent of clk.
- Threshold parameters must satisfy AE_LEVEL < AF_LEVEL <= DEPTH; check this with an elaboration-time guard.

Decomposition:
- Shared package fifo_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH constants;
  - a count-width function (ADDR_WIDTH+1).
- One natural sub-module, fifo_mem: a DEPTH×DATA_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr → rdata).
- Pointer, count, flag and handshake logic stays in param_fifo.

Test Plan:
- Reset, then rd_en=1 for one cycle on the empty FIFO -> next cycle rd_err=1, rd_ack=0, d_out=0, data_count=0, empty=1.
- Write 32'h1100_0011..32'h8800_0088 (8 words) -> wr_ack=1 each cycle, data_count 1..8, almost_full=1 from count 6, full=1 after the 8th.
- Continue writing 32'h9900_0099 and 32'haa00_00aa while full -> wr_err=1 both cycles, data_count stays 8, and the later read order is unchanged (first read returns 32'h1100_0011).
- At full, drive rd_en=wr_en=1 with d_in=32'hcc00_00cc -> rd_ack=wr_ack=1, d_out=32'h1100_0011, count stays 8. The 8th subsequent read returns 32'hcc00_00cc.
- Drain with rd_en=1 for 10 cycles -> 8 rd_ack with data in order, then rd_err=1 twice. d_out holds the last valid word; almost_empty=1 at count<=2; empty=1.
- At count 5: assert clr together with wr_en -> data_count=0, empty=1, wr_ack=0. Separately, assert reset_n low mid-burst between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 3;

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Producer/consumer handshake bundle for param_fifo; master drives requests, slave is the FIFO.
interface param_fifo_if #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
);
    localparam int unsigned CW = fifo_pkg::count_width(ADDR_WIDTH);

    logic                  clr;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] d_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
    logic [CW-1:0]         data_count;

    modport master (
        output clr, rd_en, wr_en, d_in,
        input  d_out, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  clr, rd_en, wr_en, d_in,
        output d_out, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err, data_count
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with ack/err handshakes, programmable thresholds and flush.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    param_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    // Thresholds must leave a non-empty band between almost_empty and almost_full.
    generate
        if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
            $error("param_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] d_out_q;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wr_ack_q;
    logic                  wr_err_q;
    logic                  rd_ack_q;
    logic                  rd_err_q;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  mem_we_c;

    // A write into a full FIFO is still accepted when a read frees the slot at the same edge.
    always_comb begin
        rd_acc_c = bus.rd_en && (count != '0);
        wr_acc_c = bus.wr_en && ((count != DEPTH_C) || bus.rd_en);
        mem_we_c = wr_acc_c && !bus.clr;
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (wr_ptr),
        .wdata (bus.d_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            d_out_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else if (bus.clr) begin
            // Flush wins over any request; d_out keeps the last delivered word.
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc_c) begin
                rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
                d_out_q <= rdata;
            end
            count    <= count + CW'(wr_acc_c) - CW'(rd_acc_c);
            wr_ack_q <= wr_acc_c;
            wr_err_q <= bus.wr_en && !wr_acc_c;
            rd_ack_q <= rd_acc_c;
            rd_err_q <= bus.rd_en && !rd_acc_c;
        end
    end

    assign bus.d_out        = d_out_q;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_err       = rd_err_q;
    assign bus.data_count   = count;
    assign bus.full         = (count == DEPTH_C);
    assign bus.empty        = (count == '0);
    assign bus.almost_full  = (count >= AF_C);
    assign bus.almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: directed vector table, async-reset check, then random traffic vs a queue model.
module tb_param_fifo;
    import fifo_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          c;
        bit          w;
        bit          r;
        logic [31:0] din;
        int          cnt;
        logic [31:0] dout;
        bit          wa;
        bit          we;
        bit          ra;
        bit          re;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: plain queue of stored words plus last-cycle handshake results.
    logic [31:0] mq[$];
    logic [31:0] m_dout;
    bit m_wa, m_we, m_ra, m_re;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic [31:0] dout,
                               input bit wa, input bit we, input bit ra, input bit re);
        chk({tag, ".data_count"},   32'(bus.data_count),   32'(cnt));
        chk({tag, ".d_out"},        bus.d_out,             dout);
        chk({tag, ".wr_ack"},       32'(bus.wr_ack),       32'(wa));
        chk({tag, ".wr_err"},       32'(bus.wr_err),       32'(we));
        chk({tag, ".rd_ack"},       32'(bus.rd_ack),       32'(ra));
        chk({tag, ".rd_err"},       32'(bus.rd_err),       32'(re));
        chk({tag, ".full"},         32'(bus.full),         32'(cnt == DEPTH));
        chk({tag, ".empty"},        32'(bus.empty),        32'(cnt == 0));
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(cnt >= AF));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= AE));
    endtask

    function automatic void add(input bit c, input bit w, input bit r, input logic [31:0] din,
                                input int cnt, input logic [31:0] dout,
                                input bit wa, input bit we, input bit ra, input bit re);
        vec_t v;
        v.c = c; v.w = w; v.r = r; v.din = din; v.cnt = cnt; v.dout = dout;
        v.wa = wa; v.we = we; v.ra = ra; v.re = re;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of requests just after an edge, then sample 1 time unit after the next edge.
    task automatic drive(input bit c, input bit w, input bit r, input logic [31:0] din);
        bus.clr   = c;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.d_in  = din;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit c, input bit w, input bit r, input logic [31:0] din);
        bit rd_ok, wr_ok;
        if (c) begin
            mq.delete();
            m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || r);
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(din);
            m_wa = wr_ok; m_we = w && !wr_ok;
            m_ra = rd_ok; m_re = r && !rd_ok;
        end
    endtask

    initial begin
        logic [31:0] w;
        int wp, rp;
        bit c, wr, rd;

        bus.clr = 0; bus.wr_en = 0; bus.rd_en = 0; bus.d_in = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: empty read, fill, overfill, read+write at full, drain, clr at count 5.
        add(0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            w = 32'h1100_0011 * k;
            add(0, 1, 0, w, k, 32'h0, 1, 0, 0, 0);
        end
        add(0, 1, 0, 32'h9900_0099, 8, 32'h0, 0, 1, 0, 0);
        add(0, 1, 0, 32'haa00_00aa, 8, 32'h0, 0, 1, 0, 0);
        add(0, 1, 1, 32'hcc00_00cc, 8, 32'h1100_0011, 1, 0, 1, 0);
        for (int k = 2; k <= 8; k++) begin
            w = 32'h1100_0011 * k;
            add(0, 0, 1, 32'h0, 9 - k, w, 0, 0, 1, 0);
        end
        add(0, 0, 1, 32'h0, 0, 32'hcc00_00cc, 0, 0, 1, 0);
        add(0, 0, 1, 32'h0, 0, 32'hcc00_00cc, 0, 0, 0, 1);
        add(0, 0, 1, 32'h0, 0, 32'hcc00_00cc, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) begin
            add(0, 1, 0, 32'(k), k, 32'hcc00_00cc, 1, 0, 0, 0);
        end
        add(1, 1, 0, 32'h5555_5555, 0, 32'hcc00_00cc, 0, 0, 0, 0);
        add(0, 1, 0, 32'hdead_beef, 1, 32'hcc00_00cc, 1, 0, 0, 0);
        add(0, 1, 1, 32'h1234_5678, 1, 32'hdead_beef, 1, 0, 1, 0);
        add(0, 0, 1, 32'h0, 0, 32'h1234_5678, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout,
                        vecs[i].wa, vecs[i].we, vecs[i].ra, vecs[i].re);
        end

        // Async reset mid-burst: outputs must return to reset values without a clock edge.
        drive(0, 1, 0, 32'h0bad_0001);
        drive(0, 1, 1, 32'h0bad_0002);
        bus.wr_en = 1; bus.rd_en = 1; bus.d_in = 32'h0bad_0003;
        #3;
        reset_n = 1'b0;
        #1;
        check_state("async_rst", 0, 32'h0, 0, 0, 0, 0);
        bus.wr_en = 0; bus.rd_en = 0; bus.d_in = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_rst", 0, 32'h0, 0, 0, 0, 0);

        // Random traffic; write/read bias changes per window to visit full and empty often.
        mq.delete();
        m_dout = '0;
        m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
        wp = 50; rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            c  = ($urandom_range(0, 79) == 0);
            wr = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < rp);
            w  = $urandom;
            model_step(c, wr, rd, w);
            drive(c, wr, rd, w);
            check_state($sformatf("rnd%0d", i), mq.size(), m_dout, m_wa, m_we, m_ra, m_re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
